// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multi-cycle core: opcode values, FSM state
// encoding and instruction field positions.
// ---------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SLT  = 4'h7;
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_BEQ  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_LI   = 4'hD;
    localparam logic [3:0] OP_NOP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Field LSB positions inside the 16-bit instruction word
    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;

endpackage

// File: rtl/cpu_mem_if.sv
// ---------------------------------------------------------------------------
// cpu_mem_if
// Unified instruction/data memory port with a req/ack handshake.
//   req   : request, held with addr/we/wdata stable until ack
//   we    : 1 = write, 0 = read
//   addr  : word address
//   wdata : write data
//   rdata : read data, valid while ack = 1
//   ack   : transfer completes in the cycle req & ack are both 1
// master = CPU side, slave = memory side.
// ---------------------------------------------------------------------------
interface cpu_mem_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (output req, we, addr, wdata, input  rdata, ack);
    modport slave  (input  req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/cpu_regfile.sv
// ---------------------------------------------------------------------------
// cpu_regfile
// 8 x DATA_W register file, two asynchronous read ports, one synchronous
// write port. Register 0 always reads zero; writes to it are dropped.
//   clk        : clock
//   i_reset_n  : asynchronous active-low clear of all registers
//   i_raddr_a/b: read addresses, o_rdata_a/b: read data
//   i_we, i_waddr, i_wdata: write port
// ---------------------------------------------------------------------------
module cpu_regfile #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              i_reset_n,
    input  logic [2:0]        i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [2:0]        i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b,
    input  logic              i_we,
    input  logic [2:0]        i_waddr,
    input  logic [DATA_W-1:0] i_wdata
);
    logic [7:0][DATA_W-1:0] w_regs;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign w_regs[gi] = '0;
            end else begin : g_rw
                logic [DATA_W-1:0] r_q;
                always_ff @(posedge clk or negedge i_reset_n) begin
                    if (!i_reset_n) begin
                        r_q <= '0;
                    end else if (i_we && (i_waddr == 3'(gi))) begin
                        r_q <= i_wdata;
                    end
                end
                assign w_regs[gi] = r_q;
            end
        end
    endgenerate

    assign o_rdata_a = w_regs[i_raddr_a];
    assign o_rdata_b = w_regs[i_raddr_b];
endmodule

// File: rtl/multicycle_cpu.sv
// ---------------------------------------------------------------------------
// multicycle_cpu
// Multi-cycle core: FETCH/DECODE/EXEC/MEM/WB/HALT FSM, 8-entry register
// file, ALU, loads/stores/branches/jumps/HALT over one shared memory port.
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   mem    : memory master port (req/we/addr/wdata out, rdata/ack in)
//   pc     : address of the instruction in flight
//   retire : one-cycle pulse per completed instruction
//   halted : high once HALT has executed, until reset
// ---------------------------------------------------------------------------
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int RST_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    cpu_mem_if.master         mem,
    output logic [ADDR_W-1:0] pc,
    output logic              retire,
    output logic              halted
);
    localparam int SH_W = $clog2(DATA_W);

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_pc, w_pc_next;
    logic [ADDR_W-1:0] r_ea, w_ea_next;
    logic [15:0]       r_ir, w_ir_next;
    logic [DATA_W-1:0] r_op_a, w_op_a_next;
    logic [DATA_W-1:0] r_op_b, w_op_b_next;
    logic [DATA_W-1:0] r_ld_data, w_ld_data_next;

    logic [3:0]        w_opcode;
    logic [2:0]        w_rd, w_rs1, w_rs2, w_raddr_b;
    logic [DATA_W-1:0] w_rf_a, w_rf_b, w_alu, w_rf_wdata;
    logic [DATA_W-1:0] w_imm6_d, w_imm9_d;
    logic [ADDR_W-1:0] w_imm6_a, w_pc_inc, w_ea, w_jmp_target;
    logic              w_rf_we, w_req, w_we, w_retire;

    assign w_opcode  = r_ir[OP_LSB +: 4];
    assign w_rd      = r_ir[RD_LSB +: 3];
    assign w_rs1     = r_ir[RS1_LSB +: 3];
    assign w_rs2     = r_ir[RS2_LSB +: 3];
    // Port B carries rd for BEQ (compare) and ST (store data), else rs2
    assign w_raddr_b = (w_opcode == OP_BEQ || w_opcode == OP_ST) ? w_rd : w_rs2;

    assign w_imm6_d     = DATA_W'($signed(r_ir[5:0]));
    assign w_imm9_d     = DATA_W'($signed(r_ir[8:0]));
    assign w_imm6_a     = ADDR_W'($signed(r_ir[5:0]));
    assign w_jmp_target = ADDR_W'(r_ir[11:0]);
    assign w_pc_inc     = r_pc + ADDR_W'(1);
    assign w_ea         = r_op_a[ADDR_W-1:0] + w_imm6_a;

    cpu_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk       (clk),
        .i_reset_n (reset),
        .i_raddr_a (w_rs1),
        .o_rdata_a (w_rf_a),
        .i_raddr_b (w_raddr_b),
        .o_rdata_b (w_rf_b),
        .i_we      (w_rf_we),
        .i_waddr   (w_rd),
        .i_wdata   (w_rf_wdata)
    );

    always_comb begin
        w_alu = '0;
        case (w_opcode)
            OP_ADD:  w_alu = r_op_a + r_op_b;
            OP_SUB:  w_alu = r_op_a - r_op_b;
            OP_AND:  w_alu = r_op_a & r_op_b;
            OP_OR:   w_alu = r_op_a | r_op_b;
            OP_XOR:  w_alu = r_op_a ^ r_op_b;
            OP_SLL:  w_alu = r_op_a << r_op_b[SH_W-1:0];
            OP_SRL:  w_alu = r_op_a >> r_op_b[SH_W-1:0];
            OP_SLT:  w_alu = DATA_W'($signed(r_op_a) < $signed(r_op_b));
            OP_ADDI: w_alu = r_op_a + w_imm6_d;
            OP_LI:   w_alu = w_imm9_d;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_pc      <= ADDR_W'(RST_PC);
            r_ea      <= '0;
            r_ir      <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_ld_data <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_ea      <= w_ea_next;
            r_ir      <= w_ir_next;
            r_op_a    <= w_op_a_next;
            r_op_b    <= w_op_b_next;
            r_ld_data <= w_ld_data_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_ea_next      = r_ea;
        w_ir_next      = r_ir;
        w_op_a_next    = r_op_a;
        w_op_b_next    = r_op_b;
        w_ld_data_next = r_ld_data;
        w_rf_we        = 1'b0;
        w_rf_wdata     = w_alu;
        w_req          = 1'b0;
        w_we           = 1'b0;
        w_retire       = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_req = 1'b1;
                if (mem.ack) begin
                    w_ir_next    = mem.rdata[15:0];
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_op_a_next  = w_rf_a;
                w_op_b_next  = w_rf_b;
                w_state_next = S_EXEC;
            end
            S_EXEC: begin
                w_state_next = S_FETCH;
                case (w_opcode)
                    OP_LD, OP_ST: begin
                        w_ea_next    = w_ea;
                        w_state_next = S_MEM;
                    end
                    OP_BEQ: begin
                        w_pc_next = (r_op_b == r_op_a) ? (w_pc_inc + w_imm6_a) : w_pc_inc;
                        w_retire  = 1'b1;
                    end
                    OP_JMP: begin
                        w_pc_next = w_jmp_target;
                        w_retire  = 1'b1;
                    end
                    OP_NOP: begin
                        w_pc_next = w_pc_inc;
                        w_retire  = 1'b1;
                    end
                    OP_HALT: begin
                        w_retire     = 1'b1;
                        w_state_next = S_HALT;
                    end
                    default: begin
                        w_rf_we   = 1'b1;
                        w_pc_next = w_pc_inc;
                        w_retire  = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                w_req = 1'b1;
                w_we  = (w_opcode == OP_ST);
                if (mem.ack) begin
                    if (w_opcode == OP_ST) begin
                        w_pc_next    = w_pc_inc;
                        w_retire     = 1'b1;
                        w_state_next = S_FETCH;
                    end else begin
                        w_ld_data_next = mem.rdata;
                        w_state_next   = S_WB;
                    end
                end
            end
            S_WB: begin
                w_rf_we      = 1'b1;
                w_rf_wdata   = r_ld_data;
                w_pc_next    = w_pc_inc;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            default: ;  // S_HALT: frozen until reset
        endcase
    end

    // Reset forces FETCH, whose request would otherwise be visible while reset
    // is still held; gating with reset drops req in the same cycle.
    assign mem.req   = w_req & reset;
    assign mem.we    = w_we;
    assign mem.addr  = (r_state == S_MEM) ? r_ea : r_pc;
    assign mem.wdata = r_op_b;
    assign pc        = r_pc;
    assign retire    = w_retire;
    assign halted    = (r_state == S_HALT);
endmodule

// File: tb/tb_multicycle_cpu.sv
module tb_multicycle_cpu;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] pc;
    logic       retire;
    logic       halted;

    always #5 clk = ~clk;

    cpu_mem_if #(.DATA_W(16), .ADDR_W(8)) bus ();

    multicycle_cpu #(.DATA_W(16), .ADDR_W(8), .RST_PC(0)) dut (
        .clk    (clk),
        .reset  (reset),
        .mem    (bus),
        .pc     (pc),
        .retire (retire),
        .halted (halted)
    );

    // Memory model: ack after 'waits' stall cycles; writes applied by tick()
    logic [15:0] mem [256];
    int waits = 0;
    int wcnt  = 0;
    int cyc   = 0;
    assign bus.ack   = bus.req && (wcnt == waits);
    assign bus.rdata = mem[bus.addr];
    always @(posedge clk) begin
        if (bus.req && !bus.ack) wcnt <= wcnt + 1;
        else                     wcnt <= 0;
        cyc <= cyc + 1;
    end

    typedef struct { logic [7:0] pc; int lat; } ret_t;
    typedef struct { logic [7:0] addr; logic [15:0] data; } st_t;
    ret_t exp_ret[$];
    st_t  exp_st[$];

    int checks = 0;
    int failures = 0;
    int last_cyc = 0;
    bit prev_pend = 0;
    logic [24:0] prev_bus;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_ret(input logic [7:0] p, input int lat);
        ret_t r;
        r.pc = p; r.lat = lat;
        exp_ret.push_back(r);
    endtask

    task automatic push_st(input logic [7:0] a, input logic [15:0] d);
        st_t s;
        s.addr = a; s.data = d;
        exp_st.push_back(s);
    endtask

    // One clock: wait for the falling edge, then score retires and stores
    task automatic tick();
        ret_t er;
        st_t  es;
        int   lat;
        @(negedge clk);
        if (reset) begin
            if (retire) begin
                lat = cyc - last_cyc;
                last_cyc = cyc;
                chk(32'(exp_ret.size() != 0), 32'd1, "retire_expected");
                if (exp_ret.size() != 0) begin
                    er = exp_ret.pop_front();
                    $display("retire pc=%02h latency=%0d", pc, lat);
                    chk(32'(pc), 32'(er.pc), "retire_pc");
                    chk(32'(lat), 32'(er.lat), "retire_latency");
                end
            end
            if (bus.req && bus.ack && bus.we) begin
                chk(32'(exp_st.size() != 0), 32'd1, "store_expected");
                if (exp_st.size() != 0) begin
                    es = exp_st.pop_front();
                    $display("store addr=%02h data=%04h", bus.addr, bus.wdata);
                    chk(32'(bus.addr), 32'(es.addr), "store_addr");
                    chk(32'(bus.wdata), 32'(es.data), "store_data");
                end
                mem[bus.addr] = bus.wdata;
            end
            if (bus.req && prev_pend)
                chk(32'({bus.we, bus.addr, bus.wdata}), 32'(prev_bus), "req_stable");
            prev_pend = bus.req && !bus.ack;
            prev_bus  = {bus.we, bus.addr, bus.wdata};
        end else begin
            prev_pend = 1'b0;
        end
    endtask

    task automatic enter_reset();
        reset = 1'b0;
        prev_pend = 1'b0;
        tick();
        tick();
    endtask

    task automatic leave_reset();
        reset = 1'b1;
        last_cyc = cyc - 1;  // the first FETCH cycle counts toward latency
    endtask

    task automatic wait_empty(input int max_cyc, input string tag);
        int n = 0;
        while ((exp_ret.size() != 0 || exp_st.size() != 0) && n < max_cyc) begin
            tick();
            n++;
        end
        chk(32'(exp_ret.size() + exp_st.size()), 32'd0, tag);
    endtask

    initial begin
        int n;
        // ---------------- Phase A: ALU, stores, JMP, HALT (zero wait) -------
        for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
        mem[0]  = 16'hD205;  // LI   r1,5
        mem[1]  = 16'hD5FD;  // LI   r2,-3
        mem[2]  = 16'h0650;  // ADD  r3,r1,r2
        mem[3]  = 16'h1888;  // SUB  r4,r2,r1
        mem[4]  = 16'h7A88;  // SLT  r5,r2,r1
        mem[5]  = 16'h6C88;  // SRL  r6,r2,r1
        mem[6]  = 16'hA814;  // ST   r4,[r0+20]
        mem[7]  = 16'hAA15;  // ST   r5,[r0+21]
        mem[8]  = 16'hAC16;  // ST   r6,[r0+22]
        mem[9]  = 16'hA617;  // ST   r3,[r0+23]
        mem[10] = 16'h0048;  // ADD  r0,r1,r1
        mem[11] = 16'hA018;  // ST   r0,[r0+24]
        mem[12] = 16'h8B7E;  // ADDI r5,r5,-2
        mem[13] = 16'hAA19;  // ST   r5,[r0+25]
        mem[14] = 16'hE000;  // NOP
        mem[15] = 16'hC040;  // JMP  0x40
        mem[8'h40] = 16'hF000;  // HALT
        waits = 0;
        enter_reset();
        chk(32'(bus.req),   32'd0, "rst_req");
        chk(32'(bus.we),    32'd0, "rst_we");
        chk(32'(retire),    32'd0, "rst_retire");
        chk(32'(halted),    32'd0, "rst_halted");
        chk(32'(bus.addr),  32'd0, "rst_addr");
        chk(32'(bus.wdata), 32'd0, "rst_wdata");
        chk(32'(pc),        32'd0, "rst_pc");
        for (int i = 0; i < 16; i++)
            push_ret(8'(i), (i inside {6, 7, 8, 9, 11, 13}) ? 4 : 3);
        push_ret(8'h40, 3);
        push_st(8'd20, 16'hFFF8);
        push_st(8'd21, 16'h0001);
        push_st(8'd22, 16'h07FF);
        push_st(8'd23, 16'h0002);
        push_st(8'd24, 16'h0000);
        push_st(8'd25, 16'hFFFF);
        leave_reset();
        wait_empty(200, "phaseA_done");
        n = 0;
        while (!halted && n < 5) begin tick(); n++; end
        chk(32'(halted), 32'd1, "halted");
        chk(32'(pc), 32'h40, "halt_pc");
        for (int i = 0; i < 20; i++) begin
            tick();
            chk(32'(bus.req), 32'd0, "halt_req_idle");
        end

        // ---------------- Phase B: ST/LD with 2 wait cycles -----------------
        enter_reset();
        waits = 2;
        mem[0] = 16'hD602;  // LI r3,2
        mem[1] = 16'hA60A;  // ST r3,[r0+10]
        mem[2] = 16'h9E0A;  // LD r7,[r0+10]
        mem[3] = 16'hAE0B;  // ST r7,[r0+11]
        mem[4] = 16'hF000;  // HALT
        push_ret(8'd0, 5);
        push_ret(8'd1, 8);
        push_ret(8'd2, 9);
        push_ret(8'd3, 8);
        push_ret(8'd4, 5);
        push_st(8'd10, 16'h0002);
        push_st(8'd11, 16'h0002);
        leave_reset();
        wait_empty(200, "phaseB_done");
        chk(32'(mem[10]), 32'h2, "mem10");

        // ---------------- Phase C: self-loop BEQ at 0xFF --------------------
        enter_reset();
        waits = 0;
        mem[0]     = 16'hC0FF;  // JMP 0xFF
        mem[8'hFF] = 16'hB27F;  // BEQ r1,r1,-1
        push_ret(8'h00, 3);
        for (int i = 0; i < 3; i++) push_ret(8'hFF, 3);
        leave_reset();
        wait_empty(100, "phaseC_done");
        chk(32'(pc), 32'hFF, "selfloop_pc");

        // ---------------- Phase D: BEQ +0 at 0xFF wraps to 0 ----------------
        enter_reset();
        mem[8'hFF] = 16'hB000;  // BEQ r0,r0,+0
        push_ret(8'h00, 3);
        push_ret(8'hFF, 3);
        push_ret(8'h00, 3);
        push_ret(8'hFF, 3);
        leave_reset();
        wait_empty(100, "phaseD_done");

        // ---------------- Phase E: reset during a LD memory wait ------------
        enter_reset();
        waits = 3;
        mem[0] = 16'hD205;  // LI r1,5
        mem[1] = 16'h9E05;  // LD r7,[r0+5]
        push_ret(8'd0, 6);
        leave_reset();
        n = 0;
        while (!(exp_ret.size() == 0 && bus.req && !bus.we && bus.addr == 8'd5 && !bus.ack)
               && n < 60) begin
            tick();
            n++;
        end
        chk(32'(n < 60), 32'd1, "ld_wait_reached");
        reset = 1'b0;
        #1;
        chk(32'(bus.req), 32'd0, "abort_req");
        chk(32'(retire), 32'd0, "abort_retire");
        tick();
        mem[0] = 16'hA21E;  // ST r1,[r0+30]: r1 must be cleared
        mem[1] = 16'hF000;  // HALT
        push_ret(8'd0, 10);
        push_ret(8'd1, 6);
        push_st(8'd30, 16'h0000);
        leave_reset();
        wait_empty(100, "phaseE_done");
        tick();
        chk(32'(halted), 32'd1, "phaseE_halted");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
